spi_responder: RTL and testbench
================================

Name: spi_responder

Overview:
- Synthesizable SPI peripheral-side responder: the target end of the MAX3421E-style register protocol that the NIOS SPI master drives on ARDUINO_IO.
- Holds a 32x8 register file that the SPI master reads and writes, so the USB-shield keyboard path can be emulated on-board and in simulation.
- A local host port lets game logic inject keycodes and status bits.
- Write events are strobed out to the rest of finaltop.

Parameters:
NREGS, 32, number of 8-bit registers; the address width is clog2(NREGS).
STATUS_REG, 25, register whose value is shifted out on MISO during the command byte.
SYNC_STAGES, 2, number of synchronizer flops on sclk, ss_n and mosi.

Ports:
Clk  input  1  system clock (50 MHz)
Reset_N  input  1  asynchronous, active-low reset
spi_sclk  input  1  SPI clock from the master; mode 0; frequency no higher than Clk/8
spi_ss_n  input  1  slave select, active-low
spi_mosi  input  1  master-out data, MSB first
spi_miso  output  1  slave-out data
spi_miso_oe  output  1  MISO output enable; high while selected
host_we  input  1  local register write strobe
host_addr  input  5  local register address
host_wdata  input  8  local write data
host_rdata  output  8  registered read of reg[host_addr]; 1-cycle latency
host_drop  output  1  1-cycle pulse when a host write is discarded
wr_valid  output  1  1-cycle pulse for each SPI-committed write
wr_addr  output  5  address of that write
wr_data  output  8  data of that write
busy  output  1  high when the state is not IDLE

Behaviour:
- Reset (asynchronous, Reset_N low):
  - All registers = 0x00.
  - State = IDLE.
  - spi_miso = 0, spi_miso_oe = 0.
  - wr_valid, host_drop, busy, host_rdata = 0.
  - Synchronizer flops = idle values: ss_n = 1, sclk = 0.
- Input sampling:
  - sclk, ss_n and mosi each pass through SYNC_STAGES flops plus one history flop for edge detection.
  - A raw edge is therefore acted on SYNC_STAGES+1 Clk cycles later.
  - mosi is sampled on the detected sclk rising edge.
- State machine: IDLE -> CMD -> DATA.
  - IDLE -> CMD on a detected ss_n fall:
    - bitcnt = 0; tx = reg[STATUS_REG]; spi_miso_oe = 1; spi_miso = tx[7].
  - CMD: shift mosi in on each rising edge. After the 8th rising edge, latch the command byte:
    - addr = cmd[7:3]; wr = cmd[1]; cmd bits 2, 0 are ignored.
    - If rd: set load_pending, with the next byte = reg[addr].
    - Go to DATA; bitcnt = 0.
  - DATA, write (wr = 1): after each 8th rising edge:
    - reg[addr] = byte.
    - wr_valid pulses on the following Clk cycle, with wr_addr/wr_data held until the next commit.
    - The address does not auto-increment; bytes repeat to the same register.
    - MISO shifts zeros.
  - DATA, read (wr = 0): each byte returns reg[addr], resampled at every byte boundary.
  - Any state -> IDLE on a detected ss_n rise:
    - Partial byte discarded, no commit.
    - spi_miso_oe = 0 on the same cycle.
- MISO timing:
  - On each detected sclk falling edge, tx shifts left and spi_miso = tx[7].
  - If load_pending is set at that falling edge, tx = the next byte instead of shifting, and load_pending clears.
  - The master therefore sees the next byte's MSB before its first rising edge.
- Host port:
  - host_we writes reg[host_addr] in the same cycle.
  - If an SPI commit targets the same address in the same cycle, the SPI write wins and host_drop pulses.
  - Host writes to other addresses proceed concurrently.
  - host_rdata reflects the register contents after any write in that cycle, on the next cycle.
- Boundaries:
  - If ss_n falls while sclk is high (a mode violation), stay IDLE until sclk is low.
  - Extra sclk edges while ss_n is high are ignored.
  - An address of NREGS or above (when NREGS < 32): writes are dropped and reads return 0x00.
  - A command byte only (no data bytes) commits nothing.
  - bitcnt wraps 7 -> 0 at each byte boundary.

Decomposition:
- Shared package spi_resp_pkg:
  - typedef state_t {IDLE, CMD, DATA}.
  - Constants CMD_WR_BIT = 1, CMD_ADDR_MSB = 7, CMD_ADDR_LSB = 3, STATUS_REG_DEFAULT = 25.
- Sub-module: sync_edge_det, one instance per input. It contains the SYNC_STAGES synchronizer, and outputs level, rise and fall.

Test Plan:
- Reset mid-byte: Reset_N low after 3 sclk bits -> outputs at reset values, reg[5] remains 0x00, spi_miso_oe = 0.
- Write: SPI command 0x2A (addr 5, wr), then byte 0xC3 -> reg[5] = 0xC3; wr_valid pulses once with wr_addr = 5, wr_data = 0xC3; host read of addr 5 returns 0xC3.
- Read with status: host writes reg[25] = 0x81 and reg[7] = 0x5A; SPI command 0x38 (addr 7, rd) plus 2 dummy bytes -> MISO returns 0x81, 0x5A, 0x5A.
- Abort: ss_n rises after 4 data bits of a write to addr 3 -> reg[3] unchanged, no wr_valid, state = IDLE, busy = 0.
- Collision: SPI write of 0x11 to addr 9 coincides with host_we of 0x22 to addr 9 -> reg[9] = 0x11, host_drop pulses once; in the same cycle a host write to addr 10 of 0x33 succeeds.
- Burst: command 0x0A (addr 1, wr) with bytes 0x01, 0x02, 0x03 at sclk = Clk/8 -> three wr_valid pulses, final reg[1] = 0x03.

Source files
------------

// File: rtl/spi_resp_pkg.sv
// Shared types and command-byte field positions for the SPI register responder.
`timescale 1ns/1ps
package spi_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int CMD_WR_BIT         = 1;
  localparam int CMD_ADDR_MSB       = 7;
  localparam int CMD_ADDR_LSB       = 3;
  localparam int STATUS_REG_DEFAULT = 25;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous input, with a history flop for edge detection.
`timescale 1ns/1ps
module sync_edge_det #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 target for the MAX3421E-style register protocol: command byte, then data bytes
// to/from a small register file that local logic can also read and write.
`timescale 1ns/1ps
module spi_responder
  import spi_resp_pkg::*;
#(
  parameter int NREGS       = 32,
  parameter int STATUS_REG  = STATUS_REG_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Reset_N,
  input  logic       spi_sclk,
  input  logic       spi_ss_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic       host_we,
  input  logic [4:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       host_drop,
  output logic       wr_valid,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam int AW = $clog2(NREGS);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_mosi_edges;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
    .clk(Clk), .rst_n(Reset_N), .din(spi_sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss (
    .clk(Clk), .rst_n(Reset_N), .din(spi_ss_n),
    .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
    .clk(Clk), .rst_n(Reset_N), .din(spi_mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );
  assign unused_mosi_edges = mosi_rise ^ mosi_fall;

  state_t     state, state_nxt;
  logic [7:0] regs [NREGS];
  logic [2:0] bitcnt;
  logic [7:0] rx, tx;
  logic [4:0] addr;
  logic       wr, load_pending, arm;
  logic [7:0] rx_byte, rd_byte, status_byte, host_rd_nxt;
  logic       byte_done, start, addr_ok, host_ok, spi_wr, host_hit;

  assign rx_byte     = {rx[6:0], mosi_lvl};
  // A deselect in the same cycle as the 8th edge aborts the byte.
  assign byte_done   = sclk_rise && (bitcnt == 3'd7) && !ss_rise;
  // arm remembers a select that arrived while sclk was still high.
  assign start       = (state == IDLE) && (ss_fall || arm) && !ss_lvl && !sclk_lvl;
  assign addr_ok     = int'(addr) < NREGS;
  assign host_ok     = int'(host_addr) < NREGS;
  assign spi_wr      = (state == DATA) && wr && byte_done && addr_ok;
  assign host_hit    = host_we && spi_wr && (host_addr == addr);
  assign rd_byte     = addr_ok ? regs[addr[AW-1:0]] : 8'h00;
  assign status_byte = regs[AW'(STATUS_REG)];
  assign busy        = (state != IDLE);

  always_comb begin
    host_rd_nxt = 8'h00;
    if (host_ok) begin
      if (spi_wr && (host_addr == addr)) host_rd_nxt = rx_byte;
      else if (host_we)                  host_rd_nxt = host_wdata;
      else                               host_rd_nxt = regs[host_addr[AW-1:0]];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CMD;
      CMD:     if (ss_rise) state_nxt = IDLE;
               else if (byte_done) state_nxt = DATA;
      DATA:    if (ss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state        <= IDLE;
      arm          <= 1'b0;
      bitcnt       <= 3'd0;
      rx           <= 8'h00;
      tx           <= 8'h00;
      addr         <= 5'd0;
      wr           <= 1'b0;
      load_pending <= 1'b0;
      spi_miso     <= 1'b0;
      spi_miso_oe  <= 1'b0;
      wr_valid     <= 1'b0;
      wr_addr      <= 5'd0;
      wr_data      <= 8'h00;
      host_drop    <= 1'b0;
      host_rdata   <= 8'h00;
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
    end else begin
      state      <= state_nxt;
      wr_valid   <= spi_wr;
      host_drop  <= host_hit;
      host_rdata <= host_rd_nxt;

      if (host_we && host_ok && !host_hit) regs[host_addr[AW-1:0]] <= host_wdata;
      if (spi_wr) begin
        regs[addr[AW-1:0]] <= rx_byte;
        wr_addr            <= addr;
        wr_data            <= rx_byte;
      end

      if (ss_rise)      arm <= 1'b0;
      else if (ss_fall) arm <= 1'b1;

      if (start) begin
        arm          <= 1'b0;
        bitcnt       <= 3'd0;
        tx           <= status_byte;
        spi_miso     <= status_byte[7];
        spi_miso_oe  <= 1'b1;
        load_pending <= 1'b0;
      end else if (state != IDLE) begin
        if (ss_rise) begin
          spi_miso_oe  <= 1'b0;
          spi_miso     <= 1'b0;
          load_pending <= 1'b0;
          bitcnt       <= 3'd0;
        end else if (sclk_rise) begin
          rx     <= rx_byte;
          bitcnt <= bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            if (state == CMD) begin
              addr         <= rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
              wr           <= rx_byte[CMD_WR_BIT];
              load_pending <= !rx_byte[CMD_WR_BIT];
            end else begin
              load_pending <= !wr;
            end
          end
        end else if (sclk_fall) begin
          // The next read byte is fetched here so the master sees its MSB before the first rising edge.
          if (load_pending) begin
            tx           <= rd_byte;
            spi_miso     <= rd_byte[7];
            load_pending <= 1'b0;
          end else begin
            tx       <= {tx[6:0], 1'b0};
            spi_miso <= tx[6];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: a bit-banged SPI master at Clk/8 plus host-port stimulus and scoreboards.
`timescale 1ns/1ps
module tb_spi_responder;

  logic       Clk = 1'b0;
  logic       Reset_N;
  logic       spi_sclk, spi_ss_n, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic       host_we;
  logic [4:0] host_addr;
  logic [7:0] host_wdata, host_rdata;
  logic       host_drop, wr_valid, busy;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;

  int errors = 0;
  int checks = 0;

  // Observed write events and drop pulses, logged by the monitor only.
  logic [12:0] obs_wr [0:63];
  int          wr_cnt   = 0;
  int          drop_cnt = 0;
  int          wr_seen  = 0;

  logic [12:0] exp_wr_q [$];
  logic [7:0]  exp_miso_q [$];
  logic [12:0] exp_w;
  logic [7:0]  exp_b, got;

  always #10 Clk = ~Clk;

  spi_responder dut (
    .Clk(Clk), .Reset_N(Reset_N),
    .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_drop(host_drop),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always @(negedge Clk) begin
    if (wr_valid === 1'b1) begin
      if (wr_cnt < 64) obs_wr[wr_cnt] = {wr_addr, wr_data};
      wr_cnt++;
    end
    if (host_drop === 1'b1) drop_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1ms, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic spi_bits(input logic [7:0] tx, input int nbits, input logic inj,
                          input logic [4:0] ia, input logic [7:0] id, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      @(negedge Clk);
      spi_mosi = tx[7-i];
      repeat (3) @(negedge Clk);
      rx[7-i]  = spi_miso;
      spi_sclk = 1'b1;
      if (inj && i == 7) begin
        repeat (2) @(negedge Clk);
        host_we = 1'b1; host_addr = ia; host_wdata = id;
        @(negedge Clk);
        host_we = 1'b0;
        @(negedge Clk);
      end else begin
        repeat (4) @(negedge Clk);
      end
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, 1'b0, 5'd0, 8'h00, rx);
  endtask

  task automatic spi_select();
    @(negedge Clk);
    spi_ss_n = 1'b0;
    repeat (6) @(negedge Clk);
  endtask

  task automatic spi_deselect();
    repeat (4) @(negedge Clk);
    spi_ss_n = 1'b1;
    repeat (6) @(negedge Clk);
  endtask

  task automatic host_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge Clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge Clk);
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [4:0] a, output logic [7:0] d);
    @(negedge Clk);
    host_addr = a;
    @(negedge Clk);
    d = host_rdata;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b want 0", spi_miso_oe); end
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL rst_miso: got %b want 0", spi_miso); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if ({wr_valid, host_drop} !== 2'b00) begin errors++; $display("FAIL rst_pulses: got %b want 00", {wr_valid, host_drop}); end
    checks++; if (host_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h want 00", host_rdata); end
    Reset_N = 1'b1;
    host_write(5'd5, 8'h77);
    spi_select();
    spi_bits(8'h2A, 3, 1'b0, 5'd0, 8'h00, rd);
    checks++; if ({busy, spi_miso_oe} !== 2'b11) begin errors++; $display("FAIL mid_byte_active: got busy,oe=%b want 11", {busy, spi_miso_oe}); end
    Reset_N = 1'b0;
    #1;
    checks++; if ({busy, spi_miso_oe, spi_miso} !== 3'b000) begin errors++; $display("FAIL mid_rst_outputs: got busy,oe,miso=%b want 000", {busy, spi_miso_oe, spi_miso}); end
    checks++; if (host_rdata !== 8'h00) begin errors++; $display("FAIL mid_rst_rdata: got %h want 00", host_rdata); end
    spi_ss_n = 1'b1;
    spi_sclk = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_N = 1'b1;
    repeat (6) @(negedge Clk);
    host_read(5'd5, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL mid_rst_reg5: got %h want 00", rd); end
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL mid_rst_wr: got %0d writes want 0", wr_cnt); end
  endtask

  task automatic test_write();
    logic [7:0] rd;
    spi_select();
    spi_byte(8'h2A, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL wr_status_miso: got %h want 00", rd); end
    exp_wr_q.push_back({5'd5, 8'hC3});
    spi_byte(8'hC3, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL wr_data_miso: got %h want 00", rd); end
    spi_deselect();
    while (exp_wr_q.size() > 0) begin
      exp_w = exp_wr_q.pop_front();
      checks++;
      if (wr_seen >= wr_cnt) begin errors++; $display("FAIL wr_event_missing: got none want %h", exp_w); end
      else begin
        if (obs_wr[wr_seen] !== exp_w) begin errors++; $display("FAIL wr_event: got %h want %h", obs_wr[wr_seen], exp_w); end
        wr_seen++;
      end
    end
    checks++; if (wr_cnt !== wr_seen) begin errors++; $display("FAIL wr_extra: got %0d events want %0d", wr_cnt, wr_seen); end
    wr_seen = wr_cnt;
    host_read(5'd5, rd);
    checks++; if (rd !== 8'hC3) begin errors++; $display("FAIL wr_reg5: got %h want c3", rd); end
  endtask

  task automatic test_read_status();
    host_write(5'd25, 8'h81);
    host_write(5'd7, 8'h5A);
    exp_miso_q.push_back(8'h81);
    exp_miso_q.push_back(8'h5A);
    exp_miso_q.push_back(8'h5A);
    spi_select();
    for (int i = 0; i < 3; i++) begin
      spi_byte((i == 0) ? 8'h38 : 8'h00, got);
      exp_b = exp_miso_q.pop_front();
      checks++;
      if (got !== exp_b) begin errors++; $display("FAIL rd_byte%0d: got %h want %h", i, got, exp_b); end
    end
    spi_deselect();
    checks++; if (wr_cnt !== wr_seen) begin errors++; $display("FAIL rd_no_write: got %0d events want %0d", wr_cnt, wr_seen); end
    wr_seen = wr_cnt;
    checks++; if ({busy, spi_miso_oe} !== 2'b00) begin errors++; $display("FAIL rd_idle: got busy,oe=%b want 00", {busy, spi_miso_oe}); end
  endtask

  task automatic test_abort();
    logic [7:0] rd;
    host_write(5'd3, 8'h66);
    spi_select();
    spi_byte(8'h1A, rd);
    spi_bits(8'hFF, 4, 1'b0, 5'd0, 8'h00, rd);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_mid: got %b want 1", busy); end
    spi_deselect();
    checks++; if ({busy, spi_miso_oe} !== 2'b00) begin errors++; $display("FAIL abort_idle: got busy,oe=%b want 00", {busy, spi_miso_oe}); end
    host_read(5'd3, rd);
    checks++; if (rd !== 8'h66) begin errors++; $display("FAIL abort_reg3: got %h want 66", rd); end
    // Command byte alone commits nothing.
    spi_select();
    spi_byte(8'h2A, rd);
    spi_deselect();
    host_read(5'd5, rd);
    checks++; if (rd !== 8'hC3) begin errors++; $display("FAIL cmd_only_reg5: got %h want c3", rd); end
    checks++; if (wr_cnt !== wr_seen) begin errors++; $display("FAIL abort_no_write: got %0d events want %0d", wr_cnt, wr_seen); end
    wr_seen = wr_cnt;
  endtask

  task automatic test_collision();
    logic [7:0] rd;
    int d0;
    d0 = drop_cnt;
    spi_select();
    spi_byte(8'h4A, rd);
    exp_wr_q.push_back({5'd9, 8'h11});
    spi_bits(8'h11, 8, 1'b1, 5'd9, 8'h22, rd);
    exp_wr_q.push_back({5'd9, 8'h11});
    spi_bits(8'h11, 8, 1'b1, 5'd10, 8'h33, rd);
    spi_deselect();
    while (exp_wr_q.size() > 0) begin
      exp_w = exp_wr_q.pop_front();
      checks++;
      if (wr_seen >= wr_cnt) begin errors++; $display("FAIL coll_event_missing: got none want %h", exp_w); end
      else begin
        if (obs_wr[wr_seen] !== exp_w) begin errors++; $display("FAIL coll_event: got %h want %h", obs_wr[wr_seen], exp_w); end
        wr_seen++;
      end
    end
    wr_seen = wr_cnt;
    checks++; if (drop_cnt - d0 !== 1) begin errors++; $display("FAIL coll_drop: got %0d pulses want 1", drop_cnt - d0); end
    host_read(5'd9, rd);
    checks++; if (rd !== 8'h11) begin errors++; $display("FAIL coll_reg9: got %h want 11", rd); end
    host_read(5'd10, rd);
    checks++; if (rd !== 8'h33) begin errors++; $display("FAIL coll_reg10: got %h want 33", rd); end
  endtask

  task automatic test_boundaries();
    logic [7:0] rd;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk); spi_sclk = 1'b1;
      repeat (4) @(negedge Clk); spi_sclk = 1'b0;
      repeat (3) @(negedge Clk);
    end
    checks++; if ({busy, spi_miso_oe} !== 2'b00) begin errors++; $display("FAIL sclk_no_ss: got busy,oe=%b want 00", {busy, spi_miso_oe}); end
    @(negedge Clk); spi_sclk = 1'b1;
    repeat (4) @(negedge Clk); spi_ss_n = 1'b0;
    repeat (10) @(negedge Clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mode_violation_wait: got busy=%b want 0", busy); end
    spi_sclk = 1'b0;
    repeat (6) @(negedge Clk);
    checks++; if ({busy, spi_miso_oe} !== 2'b11) begin errors++; $display("FAIL mode_violation_start: got busy,oe=%b want 11", {busy, spi_miso_oe}); end
    spi_byte(8'h38, rd);
    checks++; if (rd !== 8'h81) begin errors++; $display("FAIL mode_violation_status: got %h want 81", rd); end
    spi_deselect();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mode_violation_end: got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    spi_select();
    spi_byte(8'h0A, rd);
    for (int i = 1; i <= 3; i++) begin
      exp_wr_q.push_back({5'd1, 8'(i)});
      spi_byte(8'(i), rd);
    end
    spi_deselect();
    checks++; if (wr_cnt - wr_seen !== 3) begin errors++; $display("FAIL burst_count: got %0d pulses want 3", wr_cnt - wr_seen); end
    while (exp_wr_q.size() > 0) begin
      exp_w = exp_wr_q.pop_front();
      checks++;
      if (wr_seen >= wr_cnt) begin errors++; $display("FAIL burst_event_missing: got none want %h", exp_w); end
      else begin
        if (obs_wr[wr_seen] !== exp_w) begin errors++; $display("FAIL burst_event: got %h want %h", obs_wr[wr_seen], exp_w); end
        wr_seen++;
      end
    end
    wr_seen = wr_cnt;
    host_read(5'd1, rd);
    checks++; if (rd !== 8'h03) begin errors++; $display("FAIL burst_reg1: got %h want 03", rd); end
  endtask

  initial begin
    Reset_N    = 1'b0;
    spi_sclk   = 1'b0;
    spi_ss_n   = 1'b1;
    spi_mosi   = 1'b0;
    host_we    = 1'b0;
    host_addr  = 5'd0;
    host_wdata = 8'h00;
    repeat (3) @(negedge Clk);
    test_reset();
    test_write();
    test_read_status();
    test_abort();
    test_collision();
    test_boundaries();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
